// File: rtl/fetch_stage.sv
// IF stage: icache fetch into a registered IF/ID latch with a one-entry stall buffer; IF/ID updates one edge after a hit.
// Optional FETCH_PERF_EN adds saturating fetch/miss counters; stall parks a hit in HOLD, and flush wins over everything.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pcout,
  output logic        pcenable,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        pcen;
  logic [31:0] pc4;

  assign pc4 = pcout + 32'd4;

  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    pcen         = 1'b0;
    case (state_q)
      FETCH, HOLD: begin
        if (flush) begin
          // Redirect: the PC unit takes the target, so the PC must still advance.
          pcen         = 1'b1;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          ifid_pc4_d   = 32'd0;
          hold_instr_d = 32'd0;
          hold_pc4_d   = 32'd0;
          state_d      = FETCH;
        end else if (halt) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          ifid_pc4_d   = 32'd0;
          hold_instr_d = 32'd0;
          hold_pc4_d   = 32'd0;
          state_d      = HALTED;
        end else if (state_q == FETCH) begin
          if (ihit) begin
            pcen = 1'b1;
            if (stall) begin
              hold_instr_d = imemload;
              hold_pc4_d   = pc4;
              state_d      = HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imemload;
              ifid_pc4_d   = pc4;
            end
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4_q;
          state_d      = FETCH;
        end
      end
      HALTED: begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = 32'd0;
      end
      default: state_d = FETCH;
    endcase
  end

  // nRST gates the request strobes so nothing leaks out while reset is held.
  assign pcenable   = pcen & nRST;
  assign imemREN    = (state_q == FETCH) & nRST;
  assign imemaddr   = pcout;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] miss_cycles_q, miss_cycles_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    miss_cycles_d = miss_cycles_q;
    if (state_q == FETCH && ihit && !flush && fetch_count_q != 32'hFFFFFFFF)
      fetch_count_d = fetch_count_q + 32'd1;
    if (state_q == FETCH && !ihit && miss_cycles_q != 32'hFFFFFFFF)
      miss_cycles_d = miss_cycles_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q <= 32'd0;
      miss_cycles_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign miss_cycles = miss_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: each vector pushes its expected IF/ID word, popped after the next edge.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hDEAD0013;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pcout = 32'd0;
  logic        pcenable, imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'd0;
  logic        stall = 1'b0, flush = 1'b0, halt = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, miss_cycles;
`endif

  fetch_stage #(.NOP_INSTR(NOP)) dut (
    .CLK(CLK), .nRST(nRST), .pcout(pcout), .pcenable(pcenable),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .stall(stall), .flush(flush), .halt(halt), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .miss_cycles(miss_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
  } ifid_t;

  ifid_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] load,
                      input logic hit, input logic st, input logic fl, input logic hl,
                      input logic e_pcen, input logic e_ren,
                      input logic e_v, input logic [31:0] e_i, input logic [31:0] e_p);
    ifid_t e;
    pcout = pc; imemload = load; ihit = hit; stall = st; flush = fl; halt = hl;
    #3;
    chk({tag, ".pcenable"}, {31'd0, pcenable}, {31'd0, e_pcen});
    chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, e_ren});
    chk({tag, ".imemaddr"}, imemaddr, pc);
    sb.push_back('{v: e_v, i: e_i, p: e_p});
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e.v});
    chk({tag, ".ifid_instr"}, ifid_instr, e.i);
    chk({tag, ".ifid_pc4"}, ifid_pc4, e.p);
  endtask

  task automatic do_reset(input string tag);
    nRST = 1'b0; ihit = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, ".rst_instr"}, ifid_instr, NOP);
    chk({tag, ".rst_pc4"}, ifid_pc4, 32'd0);
    chk({tag, ".rst_ren"}, {31'd0, imemREN}, 32'd0);
    chk({tag, ".rst_pcen"}, {31'd0, pcenable}, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1; ihit = 1'b0;
  endtask

  initial begin
    @(posedge CLK); #1;
    do_reset("reset0");

    //   tag        pcout         imemload      hit st fl hl pcen ren  v  instr         pc4
    step("hit100",  32'h100,      32'h8C010004, 1, 0, 0, 0,  1,   1,  1, 32'h8C010004, 32'h104);
    step("miss",    32'h104,      32'h0,        0, 0, 0, 0,  0,   1,  1, 32'h8C010004, 32'h104);
    step("hitstl",  32'h200,      32'hAABBCCDD, 1, 1, 0, 0,  1,   1,  1, 32'h8C010004, 32'h104);
    step("hold1",   32'h204,      32'h55555555, 1, 1, 0, 0,  0,   0,  1, 32'h8C010004, 32'h104);
    step("hold2",   32'h204,      32'h55555555, 1, 1, 0, 0,  0,   0,  1, 32'h8C010004, 32'h104);
    step("release", 32'h204,      32'h55555555, 1, 0, 0, 0,  0,   0,  1, 32'hAABBCCDD, 32'h204);
    step("flushF",  32'h300,      32'h99999999, 1, 1, 1, 0,  1,   1,  0, NOP,          32'h0);
    step("hit400",  32'h400,      32'h11112222, 1, 0, 0, 0,  1,   1,  1, 32'h11112222, 32'h404);
    step("hitstl2", 32'h404,      32'h33334444, 1, 1, 0, 0,  1,   1,  1, 32'h11112222, 32'h404);
    step("flushH",  32'h408,      32'h66666666, 1, 1, 1, 0,  1,   0,  0, NOP,          32'h0);
    step("idleF",   32'h40C,      32'h0,        0, 0, 0, 0,  0,   1,  0, NOP,          32'h0);
    step("hit500",  32'h500,      32'h77778888, 1, 0, 0, 0,  1,   1,  1, 32'h77778888, 32'h504);
    step("wrap",    32'hFFFFFFFC, 32'h12345678, 1, 0, 0, 0,  1,   1,  1, 32'h12345678, 32'h0);

    do_reset("reset1");
    for (int k = 0; k < 3; k++)
      step("pmiss", 32'h600,      32'h0,        0, 0, 0, 0,  0,   1,  0, NOP,          32'h0);
    step("phit",    32'h600,      32'h0BADF00D, 1, 0, 0, 0,  1,   1,  1, 32'h0BADF00D, 32'h604);
`ifdef FETCH_PERF_EN
    chk("miss_cycles", miss_cycles, 32'd3);
    chk("fetch_count", fetch_count, 32'd1);
`endif

    // Reset while parked in HOLD must drop the buffered word.
    step("hitstl3", 32'h700,      32'hCAFEBABE, 1, 1, 0, 0,  1,   1,  1, 32'h0BADF00D, 32'h604);
    do_reset("reset2");
    step("noleak",  32'h704,      32'h0,        0, 0, 0, 0,  0,   1,  0, NOP,          32'h0);

    step("halt",    32'h800,      32'h44444444, 1, 0, 0, 1,  0,   1,  0, NOP,          32'h0);
    for (int k = 0; k < 10; k++)
      step("halted", 32'h804,     32'h44444444, 1, 0, (k == 4), 0, 0, 0, 0, NOP,       32'h0);
    do_reset("reset3");
    step("refetch", 32'h900,      32'h0000ABCD, 1, 0, 0, 0,  1,   1,  1, 32'h0000ABCD, 32'h904);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
